// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with mask, GE and ack/EOI sequencing; define IRQ_LEVEL_TRIG_EN for level-sensitive sources
module irq_ctrl #(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic            ack,
  output logic            irq,
  output logic [IDW-1:0]  id
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, req;
  logic            ge_q, ge_d, irq_q, irq_d, valid, ack_clr;
  logic            wr_ctrl, wr_pend, wr_eoi;
  logic [IDW-1:0]  id_q, id_d, win;
  assign wr_ctrl = WE && Addr == 2'd0;
  assign wr_pend = WE && Addr == 2'd1;
  assign wr_eoi  = WE && Addr == 2'd3;
  assign req     = pend_q & mask_q;
  assign valid   = ge_q && |req;
  assign mask_d  = wr_ctrl ? Din[NSRC-1:0] : mask_q;
  assign ge_d    = wr_ctrl ? Din[31] : ge_q;
  assign irq     = irq_q;
  assign id      = id_q;
  assign Dout    = Addr == 2'd0 ? {ge_q, {(31-NSRC){1'b0}}, mask_q} :
                   Addr == 2'd1 ? {{(32-NSRC){1'b0}}, pend_q} :
                   Addr == 2'd2 ? {{(32-IDW){1'b0}}, id_q} : 32'd0;
  always_comb begin
    win = '1;
    for (int i = NSRC - 1; i >= 0; i--)
      if (req[i]) win = IDW'(i);
  end
`ifdef IRQ_LEVEL_TRIG_EN
  logic unused_ok;
  assign pend_d    = src;
  assign unused_ok = ^{Din[30:NSRC], ack_clr, wr_pend};
`else
  logic [NSRC-1:0] src_q, clr;
  logic            unused_ok;
  assign clr       = (wr_pend ? Din[NSRC-1:0] : '0) | (ack_clr ? NSRC'(1) << id_q : '0);
  assign pend_d    = (pend_q & ~clr) | (src & ~src_q);
  assign unused_ok = ^Din[30:NSRC];
  always_ff @(posedge clk)
    src_q <= reset ? '0 : src;
`endif
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    ack_clr = 1'b0;
    case (state_q)
      IDLE: if (valid) begin
        state_d = REQ;
        irq_d   = 1'b1;
        id_d    = win;
      end
      REQ: if (ack) begin
        state_d = SERV;
        irq_d   = 1'b0;
        ack_clr = 1'b1;
      end else if (!valid) begin
        state_d = IDLE;
        irq_d   = 1'b0;
        id_d    = '1;
      end else begin
        id_d    = win;
      end
      SERV: if (wr_eoi) begin
        state_d = IDLE;
        id_d    = '1;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        id_d    = '1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      id_q    <= '1;
      mask_q  <= '0;
      ge_q    <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
      ge_q    <= ge_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller between the peripheral interrupt sources (Timer IRQs, external interrupt) and the CPU's hardware interrupt input.
- Latches source edges into a pending register, applies a mask and a global enable, and selects the highest-priority source.
- Drives a single request to the CPU and sequences acknowledge / end-of-interrupt (EOI).
- Sits behind the Bridge as one more device slot and uses the same Addr/WE/Din/Dout device interface as Timer.

Parameters:
- NSRC, 6: number of interrupt sources, 1..8; source 0 has the highest priority.
- IDW, 3: width of the source ID; 2^IDW > NSRC so that all-ones can mean "none".

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- src  in  NSRC  raw interrupt lines from devices
- Addr  in  2  word select (Bridge DEVAddr[3:2])
- WE  in  1  register write enable from Bridge
- Din  in  32  write data
- Dout  out  32  read data (combinational from Addr)
- ack  in  1  one-cycle pulse from CPU on exception entry
- irq  out  1  request to CPU, registered
- id  out  IDW  ID of the requesting/in-service source; all-ones when none

Behaviour:
- Reset is synchronous and active-high, and clears everything:
  - irq=0, id=all-ones, state IDLE.
  - mask=0, GE=0, pend=0, src_q=0.
  - Dout reflects the reset register values.
- Register map (Addr):
  - 0 CTRL, R/W: [NSRC-1:0]=mask (1 = enabled), [31]=GE; other bits read 0.
  - 1 PEND, R/W1C: [NSRC-1:0] pending bits.
  - 2 ID, RO: zero-extended in-service ID, all-ones when none.
  - 3 EOI, WO: any write ends service; reads return 0.
- Edge capture:
  - src_q<=src every cycle; edge=src&~src_q.
  - pend<=(pend&~clr)|edge, where clr = W1C mask | ack-clear bit.
  - Set wins: an edge arriving in the same cycle as a clear leaves the bit at 1.
- Selection: req = pend & mask; win = lowest set index of req; valid = GE && |req.
- FSM states IDLE, REQ, SERV:
  - IDLE: if valid, go to REQ next cycle; irq<=1, id<=win.
  - REQ:
    - id tracks win every cycle, so a higher-priority arrival pre-empts the ID before ack.
    - If valid drops (mask/GE cleared, W1C), return to IDLE with irq<=0 and id<=all-ones.
    - On ack: clear pend[id], latch in-service ID, go to SERV, irq<=0.
  - SERV:
    - irq stays 0; no nesting, and new edges only accumulate in pend.
    - A WE with Addr=3 returns to IDLE.
    - If valid is still true, IDLE re-requests on the following cycle.
- ack outside REQ is ignored. EOI outside SERV is ignored.
- Latency:
  - Edge at cycle t (src=1, src_q=0): pend set at the clock ending t.
  - irq=1 from cycle t+2.
  - ack at cycle k: irq=0 from k+1.
  - EOI at cycle e with a pending source: irq=1 from e+2.
- Writes take effect at the clock edge. Dout is combinational, with no read side effects.
- Reset asserted mid-REQ or mid-SERV returns to the full reset state next edge; pending interrupts are lost.
- src bits at index >= NSRC do not exist. Din bits above NSRC-1 are ignored, except CTRL[31].

Optional Feature:
- Macro: IRQ_LEVEL_TRIG_EN.
- Defined: sources are level-sensitive.
  - pend<=src each cycle; W1C writes to PEND have no effect.
  - ack does not clear pend. In SERV, the source must be deasserted by its device before EOI, or it re-requests.
- Undefined: rising-edge capture as above.

Test Plan:
- Reset, then CTRL=0x8000_0001, src[0] 0->1 at cycle 10 -> pend=0x01 at cycle 11, irq=1 and id=0 from cycle 12; PEND reads 0x01.
- src[3] and src[1] rise in the same cycle, mask=0x0A, GE=1 -> id=1. After ack: irq=0, ID reg=1, PEND=0x08. EOI -> irq=1 with id=3 two cycles later.
- In REQ on src[4] (id=4), src[2] rises -> id becomes 2 before ack. ack -> PEND bit 2 cleared, bit 4 still 1.
- W1C write PEND=0x01 in the same cycle as a src[0] rising edge -> PEND bit 0 reads 1. GE=0 with pend set -> irq stays 0.
- Reset asserted during SERV -> next cycle irq=0, id=7, CTRL=0, PEND=0. A stray ack in IDLE and an EOI in IDLE produce no state change.
- With IRQ_LEVEL_TRIG_EN: src[5] held high through ack and EOI -> irq re-asserts two cycles after EOI. src[5] dropped before EOI -> irq stays 0.
